// File: rtl/bshift_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encoding and op type.
package bshift_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_LSR = 2'b00;
  localparam op_t OP_LSL = 2'b01;
  localparam op_t OP_ASR = 2'b10;
  localparam op_t OP_ROR = 2'b11;

endpackage

// File: rtl/bshift_stage.sv
// One shift-and-register slice of the barrel shifter.
// Stage IDX conditionally shifts by 2**IDX (selected by shamt bit IDX) and
// registers data, op, shamt, valid and a zero flag of the registered data.
// Rotate support is compiled in only when BSHIFT_ROTATE_EN is defined;
// otherwise op 11 falls through to the logical-right path.
module bshift_stage
  import bshift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX   = 0,
  localparam int SW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             prev_vld,
  input  logic [WIDTH-1:0] prev_data,
  input  logic [1:0]       prev_op,
  input  logic [SW-1:0]    prev_shamt,
  output logic             vld,
  output logic [WIDTH-1:0] data,
  output logic [1:0]       op,
  output logic [SW-1:0]    shamt,
  output logic             zero
);

  localparam int AMT = 1 << IDX;

  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                  input op_t o);
    logic signed [WIDTH-1:0] sd;
    logic        [WIDTH-1:0] r;
    sd = d;
    case (o)
      OP_LSL:  r = d << AMT;
      OP_ASR:  r = sd >>> AMT;
`ifdef BSHIFT_ROTATE_EN
      OP_ROR:  r = (d >> AMT) | (d << (WIDTH - AMT));
`endif
      default: r = d >> AMT;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] nxt;

  assign nxt = prev_shamt[IDX] ? shift_step(prev_data, prev_op) : prev_data;

  // Stage register: advances as a unit with the whole pipe, holds when stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld   <= 1'b0;
      data  <= '0;
      op    <= OP_LSR;
      shamt <= '0;
      zero  <= 1'b0;
    end else if (en) begin
      vld   <= prev_vld;
      data  <= nxt;
      op    <= prev_op;
      shamt <= prev_shamt;
      zero  <= (nxt == '0);
    end
  end

endmodule

// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter: SW = log2(WIDTH) cascaded stages, one per shift
// bit, with valid/ready handshake and a single global advance enable.
// Ops: LSR, LSL, ASR, ROR (ROR only when BSHIFT_ROTATE_EN is defined,
// otherwise op 11 behaves as LSR).
module pipe_barrel_shifter
  import bshift_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int SW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]    in_shamt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  if (WIDTH < 4 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("pipe_barrel_shifter: WIDTH must be a power of two from 4 to 64");
  end

  logic             adv;
  logic             vld_p   [SW+1];
  logic [WIDTH-1:0] data_p  [SW+1];
  logic [1:0]       op_p    [SW+1];
  logic [SW-1:0]    shamt_p [SW+1];
  logic [SW-1:0]    zero_v;
  logic             unused_bits;

  // The whole pipe moves together whenever the output slot is free or drained.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign vld_p[0]   = in_valid;
  assign data_p[0]  = in_data;
  assign op_p[0]    = in_op;
  assign shamt_p[0] = in_shamt;

  for (genvar k = 0; k < SW; k++) begin : g_stage
    bshift_stage #(
      .WIDTH (WIDTH),
      .IDX   (k)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .en         (adv),
      .prev_vld   (vld_p[k]),
      .prev_data  (data_p[k]),
      .prev_op    (op_p[k]),
      .prev_shamt (shamt_p[k]),
      .vld        (vld_p[k+1]),
      .data       (data_p[k+1]),
      .op         (op_p[k+1]),
      .shamt      (shamt_p[k+1]),
      .zero       (zero_v[k])
    );
  end

  assign out_valid = vld_p[SW];
  assign out_data  = data_p[SW];
  assign out_zero  = zero_v[SW-1];

  // Intermediate zero flags and the final op/shamt copies have no consumer.
  assign unused_bits = ^{zero_v[SW-2:0], op_p[SW], shamt_p[SW]};

endmodule
